// File: rtl/booth_pkg.sv
// booth_pkg -- shared definitions for the Booth MAC accumulator.
//   GUARD_DEF : default number of guard bits above the 2*WIDTH product
//   acc_w()   : accumulator width, 2*WIDTH + GUARD
//   state_e   : IDLE (no open sum, acc == 0) / ACCUM (at least one term absorbed)
package booth_pkg;
  localparam int GUARD_DEF = 8;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;
endpackage

// File: rtl/booth_mac_fifo2.sv
// booth_mac_fifo2 -- 2-entry FIFO holding completed sums ({ovf, sum}).
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din (caller only pushes when !full or popping same cycle)
//   pop      : remove head (caller only pops when !empty)
//   full, empty, dout : status and head entry (dout reads 0 when empty)
module booth_mac_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);
  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [1:0]         cnt_q, cnt_d;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  // Zeroed when empty so the result port is 0 after reset and between sums.
  assign dout  = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    // Push into a full FIFO with a pop reuses the head slot being vacated.
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/booth_mac_accum.sv
// booth_mac_accum -- dot-product accumulator behind a non-stallable multiplier.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/product: one product term per valid cycle (2*WIDTH bits)
//   prod_signed     : 1 sign-extends product, 0 zero-extends
//   in_last         : final term of the current dot product
//   acc_clear       : discard the running sum (a same-cycle term starts a new sum)
//   out_valid/out_ready/result/ovf : completed sums from a 2-deep FIFO
//   overrun         : sticky, a completed sum was dropped on a full FIFO
// Build option: BOOTH_MAC_SAT_EN saturates the accumulator instead of wrapping.
module booth_mac_accum
  import booth_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int GUARD = GUARD_DEF,
  localparam int ACC_W = acc_w(WIDTH, GUARD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2*WIDTH-1:0]      product,
  input  logic                    prod_signed,
  input  logic                    in_last,
  input  logic                    acc_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf,
  output logic                    overrun
);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sum_ovf_q, sum_ovf_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W-1:0] term, base, sum_raw, sum_fix;
  logic             add_ovf, new_ovf;
  logic             push, push_ok, pop, full, empty;
  logic [ACC_W:0]   head;

  // Clear takes effect before the same-cycle term is added.
  always_comb begin
    term    = {{GUARD{prod_signed & product[2*WIDTH-1]}}, product};
    base    = acc_clear ? '0 : acc_q;
    sum_raw = base + term;
    // Signed overflow: like-signed operands giving an opposite-signed sum.
    add_ovf = (base[ACC_W-1] == term[ACC_W-1]) && (sum_raw[ACC_W-1] != base[ACC_W-1]);
    new_ovf = (!acc_clear && sum_ovf_q) || add_ovf;
`ifdef BOOTH_MAC_SAT_EN
    sum_fix = add_ovf ? (base[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    sum_fix = sum_raw;
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sum_ovf_d = sum_ovf_q;
    overrun_d = overrun_q;
    push      = 1'b0;
    if (in_valid) begin
      if (in_last) begin
        push      = 1'b1;
        acc_d     = '0;
        sum_ovf_d = 1'b0;
        state_d   = IDLE;
        if (full && !pop) overrun_d = 1'b1;
      end else begin
        acc_d     = sum_fix;
        sum_ovf_d = new_ovf;
        state_d   = ACCUM;
      end
    end else if (acc_clear) begin
      acc_d     = '0;
      sum_ovf_d = 1'b0;
      state_d   = IDLE;
    end
  end

  assign pop     = !empty && out_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      sum_ovf_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sum_ovf_q <= sum_ovf_d;
      overrun_q <= overrun_d;
    end
  end

  booth_mac_fifo2 #(.DW(ACC_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   ({new_ovf, sum_fix}),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  assign out_valid = !empty;
  assign result    = head[ACC_W-1:0];
  assign ovf       = head[ACC_W];
  assign overrun   = overrun_q;
endmodule

// File: doc/booth_mac_accum.md
BOOTH_MAC_ACCUM -- requirements
Module: booth_mac_accum

Interface
REQ-001 The parameters SHALL be: WIDTH, default 32, operand width of the upstream multiplier.
REQ-002 The parameters SHALL also include GUARD, default 8, guard bits added above the product width; ACC_W = 2*WIDTH+GUARD.
REQ-003 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and is the reset: synchronous, active-high.
REQ-005 The port in_valid SHALL be an input, 1 bit wide, and qualifies product for this cycle.
REQ-006 The port product SHALL be an input, 2*WIDTH bits wide, carrying the multiplier result, aligned with in_valid.
REQ-007 The port prod_signed SHALL be an input, 1 bit wide: 1 sign-extends product to ACC_W, 0 zero-extends it.
REQ-008 The port in_last SHALL be an input, 1 bit wide, and marks the final term of a dot product; it is meaningful only with in_valid.
REQ-009 The port acc_clear SHALL be an input, 1 bit wide, and discards the running sum.
REQ-010 The port out_valid SHALL be an output, 1 bit wide, and indicates that result holds a completed sum.
REQ-011 The port out_ready SHALL be an input, 1 bit wide, and is the consumer's acceptance; the transfer occurs when out_valid and out_ready are both high.
REQ-012 The port result SHALL be an output, ACC_W bits wide, signed, carrying the completed dot product.
REQ-013 The port ovf SHALL be an output, 1 bit wide, and is high when the current result saturated or wrapped.
REQ-014 The port overrun SHALL be an output, 1 bit wide, a sticky flag set when a completed sum was dropped.

Function
REQ-015 The block SHALL take no input backpressure (the upstream pipeline cannot stall); every in_valid term is consumed in its cycle.
REQ-016 The running sum acc SHALL update one cycle after in_valid: acc <= acc + ext(product), with the extension selected by prod_signed.
REQ-017 Simultaneous acc_clear and in_valid SHALL give acc <= ext(product), i.e. clear first, then the term is the first of a new sum.
REQ-018 acc_clear without in_valid SHALL give acc <= 0; completed sums already queued are unaffected.
REQ-019 in_valid with in_last SHALL push acc+ext(product) (after any acc_clear) into the result queue and set acc <= 0; the result is visible on result/out_valid on the next cycle when the queue was empty.
REQ-020 The result queue SHALL be 2 deep and first-in first-out; result/ovf SHALL show the head entry; out_valid = queue not empty.
REQ-021 A push with the queue full and no pop in the same cycle SHALL drop the new sum and set overrun; a push with full plus pop in the same cycle SHALL be accepted.
REQ-022 result and ovf SHALL remain stable while out_valid is high and out_ready is low.
REQ-023 The internal state SHALL be IDLE (acc==0 and no open sum) or ACCUM (at least one term absorbed); IDLE->ACCUM on in_valid without in_last; ACCUM->IDLE on in_last or acc_clear; in_last in IDLE pushes a single-term sum.
REQ-024 Per-sum overflow SHALL be tracked from the first term and SHALL be cleared when the sum is pushed or when acc_clear is asserted.

Reset
REQ-025 While rst is high at a clock edge, the block SHALL set acc=0, state=IDLE, queue empty, out_valid=0, result=0, ovf=0, overrun=0.
REQ-026 Reset mid-sum or with a non-empty queue SHALL discard everything; inputs in the reset cycle SHALL be ignored.

Configuration
REQ-027 With BOOTH_MAC_SAT_EN defined, acc SHALL saturate at the signed ACC_W max/min and set the per-sum overflow; further terms SHALL accumulate from the clamped value.
REQ-028 Without BOOTH_MAC_SAT_EN, acc SHALL wrap modulo 2^ACC_W and the per-sum overflow SHALL record that a signed wrap occurred.

Structure
REQ-029 The package booth_pkg SHALL hold the default GUARD, the ACC_W computation and the IDLE/ACCUM state encoding.
REQ-030 The result queue SHALL be the sub-module booth_mac_fifo2 (2-entry, with push, pop, full and empty, and data of ACC_W+1 bits including ovf).

Verification (WIDTH=8, GUARD=8, out_ready=1 unless noted)
REQ-031 The bench SHALL cover: signed terms -3, 5, -7 with last on the third term -> one cycle later result=-5, out_valid=1 for exactly 1 cycle.
REQ-032 The bench SHALL cover: unsigned 255*255=0xFE01 with prod_signed=0, in_last -> result=0x00FE01; the same bits with prod_signed=1 -> result=-511.
REQ-033 The bench SHALL cover: out_ready=0, three single-term sums 1, 2, 3 -> the queue holds 1, 2; overrun=1; after out_ready=1, 1 then 2 are delivered and the sum 3 is never delivered.
REQ-034 The bench SHALL cover: acc_clear with in_valid term 9 in the middle of a sum of 100, then a term of 1 with last -> result=10.
REQ-035 The bench SHALL cover: 300 terms of 0x7FFF (signed), last -> with SAT_EN result=0x7FFFFF and ovf=1; without SAT_EN the wrapped value appears and ovf=1.
REQ-036 The bench SHALL cover: rst asserted mid-sum with a full queue -> the next cycle has out_valid=0 and overrun=0, and a new sum of 4 gives result=4.
